// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the five-stage pipeline. Takes the registered EX/MEM fields,
//   runs loads/stores over a req/ack data-memory bus of variable latency
//   (byte/half lane steering, sign/zero extension), stalls everything upstream
//   while an access is outstanding, and registers results toward MEM/WB.
//
// Ports
//   clk, rst            pipeline clock, synchronous active-high reset
//   ex_valid, *_in      EX/MEM fields (alures_in is the byte address)
//   dm_req/we/addr/     data-memory request, held stable while outstanding
//   dm_wdata/dm_be
//   dm_ack, dm_rdata    one-cycle completion pulse and read word
//   mem_stall           combinational freeze of EX/MEM and earlier stages
//   wb_*                registered MEM/WB-side results
//   misalign_err        one-cycle pulse: misaligned access dropped
//   bus_err             one-cycle pulse: access aborted after TIMEOUT cycles
//
// Parameters
//   TIMEOUT             BUSY cycles without dm_ack before abort; 0 disables
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] PC_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic [1:0]  MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic [1:0]  RegWrite_in,
  input  logic [2:0]  WDSel_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_PC,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alures,
  output logic [31:0] wb_memdata,
  output logic [31:0] wb_imm,
  output logic [1:0]  wb_RegWrite,
  output logic [2:0]  wb_WDSel,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Instruction captured at request time; the result is built from this copy
  // so the writeback does not depend on EX/MEM staying frozen.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alures;
    logic [31:0] imm;
    logic [1:0]  regwrite;
    logic [2:0]  wdsel;
    logic [2:0]  dmtype;
    logic        store;
  } mem_rec_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] to_cnt;
  logic          timeout_hit;
  mem_rec_t      rec;

  logic          is_store, is_load, mem_op, aligned;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  // ---- decode of the EX/MEM instruction ----
  assign is_store = (MemWrite_in != 2'b00);
  assign is_load  = (WDSel_in == 3'b001);
  assign mem_op   = ex_valid & (is_store | is_load);

  always_comb begin
    aligned = (alures_in[1:0] == 2'b00);
    case (DMType_in)
      3'd1, 3'd2: aligned = ~alures_in[0];
      3'd3, 3'd4: aligned = 1'b1;
      default:    ;
    endcase
  end

  // Store data is replicated across lanes so memory only needs dm_be.
  always_comb begin
    st_wdata = rs2_data_in;
    st_be    = 4'b1111;
    case (DMType_in)
      3'd1, 3'd2: begin
        st_wdata = {2{rs2_data_in[15:0]}};
        st_be    = alures_in[1] ? 4'b1100 : 4'b0011;
      end
      3'd3, 3'd4: begin
        st_wdata = {4{rs2_data_in[7:0]}};
        st_be    = 4'b0001 << alures_in[1:0];
      end
      default: ;
    endcase
  end

  // ---- load lane select and extension ----
  assign ld_byte = dm_rdata[{rec.alures[1:0], 3'b000} +: 8];
  assign ld_half = rec.alures[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    ld_data = dm_rdata;
    case (rec.dmtype)
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = {16'h0000, ld_half};
      3'd3:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h000000, ld_byte};
      default: ;
    endcase
  end

  // to_cnt holds the number of BUSY cycles already spent without ack, so the
  // abort fires in the TIMEOUT-th such cycle; an ack in that cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && !dm_ack &&
                       (to_cnt == CW'(TIMEOUT - 1));

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == BUSY && !dm_ack && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                                          to_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: if (mem_op && aligned) begin
        state_nxt = BUSY;
        mem_stall = 1'b1;
      end
      BUSY: if (dm_ack || timeout_hit) state_nxt = IDLE;
            else                       mem_stall = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  // ---- bus request and MEM/WB registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      dm_be        <= '0;
      rec          <= '0;
      wb_valid     <= 1'b0;
      wb_PC        <= '0;
      wb_rd        <= '0;
      wb_alures    <= '0;
      wb_memdata   <= '0;
      wb_imm       <= '0;
      wb_RegWrite  <= '0;
      wb_WDSel     <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // Anything that does not retire a real instruction leaves a bubble.
      wb_valid     <= 1'b0;
      wb_RegWrite  <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (aligned) begin
              dm_req   <= 1'b1;
              dm_we    <= is_store;
              dm_addr  <= {alures_in[31:2], 2'b00};
              dm_wdata <= is_store ? st_wdata : 32'h0;
              dm_be    <= is_store ? st_be : 4'b1111;
              rec      <= '{pc: PC_in, rd: rd_in, alures: alures_in, imm: imm_in,
                            regwrite: RegWrite_in, wdsel: WDSel_in,
                            dmtype: DMType_in, store: is_store};
            end else begin
              misalign_err <= 1'b1;
            end
          end else begin
            wb_valid    <= ex_valid;
            wb_RegWrite <= ex_valid ? RegWrite_in : 2'b00;
            wb_PC       <= PC_in;
            wb_rd       <= rd_in;
            wb_alures   <= alures_in;
            wb_imm      <= imm_in;
            wb_WDSel    <= WDSel_in;
            wb_memdata  <= '0;
          end
        end
        BUSY: begin
          if (dm_ack) begin
            dm_req      <= 1'b0;
            wb_valid    <= 1'b1;
            wb_RegWrite <= rec.regwrite;
            wb_PC       <= rec.pc;
            wb_rd       <= rec.rd;
            wb_alures   <= rec.alures;
            wb_imm      <= rec.imm;
            wb_WDSel    <= rec.wdsel;
            wb_memdata  <= rec.store ? 32'h0 : ld_data;
          end else if (timeout_hit) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level reference
// model. The model tracks only "is an access outstanding, and for how many
// cycles" and derives lanes/extension arithmetically from access size.
module tb_mem_access_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        ev;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [1:0]  mw;
    logic [2:0]  dmt;
    logic [1:0]  rw;
    logic [2:0]  wds;
  } instr_t;

  logic clk, rst;
  instr_t cur;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_req, dm_we, mem_stall, wb_valid, misalign_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_PC, wb_alures, wb_memdata, wb_imm;
  logic [3:0]  dm_be;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_RegWrite;
  logic [2:0]  wb_WDSel;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(cur.ev), .PC_in(cur.pc), .rd_in(cur.rd),
    .alures_in(cur.alu), .rs2_data_in(cur.rs2), .imm_in(cur.imm),
    .MemWrite_in(cur.mw), .DMType_in(cur.dmt), .RegWrite_in(cur.rw),
    .WDSel_in(cur.wds), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_PC(wb_PC), .wb_rd(wb_rd),
    .wb_alures(wb_alures), .wb_memdata(wb_memdata), .wb_imm(wb_imm),
    .wb_RegWrite(wb_RegWrite), .wb_WDSel(wb_WDSel),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int lat;            // busy cycle in which memory acks; 0 = never
  bit stray_en;
  bit use_fix;
  logic [31:0] rdata_fix;
  bit e_stall;

  // ---------------- specification arithmetic ----------------
  function automatic int sz(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic bit is_mem(input instr_t i);
    return i.ev && (i.mw != 2'd0 || i.wds == 3'b001);
  endfunction

  function automatic bit aligned_f(input logic [2:0] t, input logic [31:0] a);
    return (a % 32'(sz(t))) == 32'd0;
  endfunction

  function automatic logic [31:0] mask_f(input int s);
    return (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] t, input logic [31:0] a);
    int m;
    m = ((1 << sz(t)) - 1) << int'(a % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] t, input logic [31:0] d);
    int s;
    logic [31:0] piece, r;
    s = sz(t);
    piece = d & mask_f(s);
    r = 32'd0;
    for (int i = 0; i < 4 / s; i++) r = r | (piece << (8 * s * i));
    return r;
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] rd);
    int s;
    logic [31:0] m, v;
    s = sz(t);
    m = mask_f(s);
    v = (rd >> (8 * int'(a % 32'd4))) & m;
    if ((t == 3'd1 || t == 3'd3) && v[8 * s - 1]) v = v | ~m;
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy;
  int          m_wait;   // busy cycles already spent without ack
  instr_t      m_rec;
  logic        e_req, e_we, e_v, e_memop, e_mis, e_berr;
  logic [31:0] e_addr, e_wdata, e_pc, e_alu, e_mem, e_imm;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic [1:0]  e_rw;
  logic [2:0]  e_wds;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_wait <= 0; m_rec <= '0;
      e_req <= 0; e_we <= 0; e_addr <= 0; e_wdata <= 0; e_be <= 0;
      e_v <= 0; e_rw <= 0; e_pc <= 0; e_rd <= 0; e_alu <= 0; e_mem <= 0;
      e_imm <= 0; e_wds <= 0; e_memop <= 0; e_mis <= 0; e_berr <= 0;
    end else begin
      e_mis <= 1'b0;
      e_berr <= 1'b0;
      if (!m_busy) begin
        if (is_mem(cur)) begin
          e_v <= 1'b0; e_rw <= 2'd0;
          if (aligned_f(cur.dmt, cur.alu)) begin
            m_busy <= 1'b1; m_wait <= 0; m_rec <= cur;
            e_req <= 1'b1;
            e_we <= (cur.mw != 2'd0);
            e_addr <= cur.alu & ~32'd3;
            e_wdata <= wdata_f(cur.dmt, cur.rs2);
            e_be <= (cur.mw != 2'd0) ? be_f(cur.dmt, cur.alu) : 4'hF;
          end else e_mis <= 1'b1;
        end else begin
          e_v <= cur.ev; e_rw <= cur.ev ? cur.rw : 2'd0;
          e_pc <= cur.pc; e_rd <= cur.rd; e_alu <= cur.alu; e_imm <= cur.imm;
          e_wds <= cur.wds; e_memop <= 1'b0;
        end
      end else if (dm_ack) begin
        m_busy <= 1'b0; e_req <= 1'b0;
        e_v <= 1'b1; e_rw <= m_rec.rw;
        e_pc <= m_rec.pc; e_rd <= m_rec.rd; e_alu <= m_rec.alu;
        e_imm <= m_rec.imm; e_wds <= m_rec.wds; e_memop <= 1'b1;
        e_mem <= (m_rec.mw != 2'd0) ? 32'd0 : load_f(m_rec.dmt, m_rec.alu, dm_rdata);
      end else if (TO != 0 && m_wait + 1 == TO) begin
        m_busy <= 1'b0; e_req <= 1'b0; e_berr <= 1'b1;
        e_v <= 1'b0; e_rw <= 2'd0;
      end else begin
        m_wait <= m_wait + 1;
        e_v <= 1'b0; e_rw <= 2'd0;
      end
    end
  end

  function automatic bit exp_stall_f();
    if (rst) return 1'b0;
    if (!m_busy) return is_mem(cur) && aligned_f(cur.dmt, cur.alu);
    return !dm_ack && !(TO != 0 && m_wait + 1 == TO);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    e_stall = exp_stall_f();
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    chk("dm_req", 32'(dm_req), 32'(e_req));
    chk("misalign_err", 32'(misalign_err), 32'(e_mis));
    chk("bus_err", 32'(bus_err), 32'(e_berr));
    chk("wb_valid", 32'(wb_valid), 32'(e_v));
    chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e_rw));
    if (e_req) begin
      chk("dm_we", 32'(dm_we), 32'(e_we));
      chk("dm_addr", dm_addr, e_addr);
      chk("dm_be", 32'(dm_be), 32'(e_be));
      if (e_we) chk("dm_wdata", dm_wdata, e_wdata);
    end
    if (e_v) begin
      chk("wb_PC", wb_PC, e_pc);
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_alures", wb_alures, e_alu);
      chk("wb_imm", wb_imm, e_imm);
      chk("wb_WDSel", 32'(wb_WDSel), 32'(e_wds));
      if (e_memop) chk("wb_memdata", wb_memdata, e_mem);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dm_req"}, 32'(dm_req), 32'd0);
    chk({tag, "_dm_we"}, 32'(dm_we), 32'd0);
    chk({tag, "_dm_addr"}, dm_addr, 32'd0);
    chk({tag, "_dm_wdata"}, dm_wdata, 32'd0);
    chk({tag, "_dm_be"}, 32'(dm_be), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_PC"}, wb_PC, 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_alures"}, wb_alures, 32'd0);
    chk({tag, "_wb_memdata"}, wb_memdata, 32'd0);
    chk({tag, "_wb_imm"}, wb_imm, 32'd0);
    chk({tag, "_wb_RegWrite"}, 32'(wb_RegWrite), 32'd0);
    chk({tag, "_wb_WDSel"}, 32'(wb_WDSel), 32'd0);
    chk({tag, "_misalign_err"}, 32'(misalign_err), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input instr_t ins, input bit r, input bit force_ack);
    @(posedge clk);
    #1;
    cur = ins;
    rst = r;
    dm_rdata = use_fix ? rdata_fix : $urandom();
    if (force_ack)   dm_ack = 1'b1;
    else if (m_busy) dm_ack = (lat != 0) && (m_wait + 1 == lat);
    else             dm_ack = stray_en && ($urandom_range(3) == 0);
    @(negedge clk);
    compare_cycle();
  endtask

  // Hold one instruction in EX/MEM until the expected stall releases it.
  task automatic issue(input instr_t ins, input int l, output int n_stall,
                       output int n_req, output logic [31:0] f_addr,
                       output logic [31:0] f_wdata, output logic [3:0] f_be);
    int cyc;
    bit seen;
    cyc = 0; seen = 0; lat = l;
    n_stall = 0; n_req = 0; f_addr = '0; f_wdata = '0; f_be = '0;
    do begin
      step(ins, 1'b0, 1'b0);
      cyc++;
      if (mem_stall) n_stall++;
      if (dm_req) begin
        n_req++;
        if (!seen) begin
          seen = 1; f_addr = dm_addr; f_wdata = dm_wdata; f_be = dm_be;
        end
      end
    end while (e_stall && cyc < 20);
    if (e_stall) begin
      total++; bad++;
      $display("FAIL issue_budget: still stalled after %0d cycles, expected release", cyc);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind = int'($urandom_range(2));
    i.ev = ($urandom_range(9) != 0);
    i.pc = $urandom(); i.rd = 5'($urandom()); i.alu = $urandom();
    i.rs2 = $urandom(); i.imm = $urandom(); i.rw = 2'($urandom());
    i.dmt = 3'($urandom_range(4));
    case (kind)
      0:       begin i.mw = 2'd0; i.wds = 3'(2 * $urandom_range(2)); end
      1:       begin i.mw = 2'd0; i.wds = 3'b001; end
      default: begin i.mw = 2'($urandom_range(3, 1)); i.wds = 3'd0; end
    endcase
    return i;
  endfunction

  instr_t bub, ins;
  int ns, nr;
  logic [31:0] fa, fw;
  logic [3:0] fb;

  initial begin
    rst = 1'b1; cur = '0; dm_ack = 1'b0; dm_rdata = '0;
    lat = 0; stray_en = 0; use_fix = 0; rdata_fix = '0;
    bub = '0;

    // model pins
    chk("pin_lb", load_f(3'd3, 32'h103, 32'h80AA_BBCC), 32'hFFFF_FF80);
    chk("pin_lbu", load_f(3'd4, 32'h103, 32'h80AA_BBCC), 32'h0000_0080);
    chk("pin_sh_be", 32'(be_f(3'd1, 32'h206)), 32'hC);
    chk("pin_sh_wdata", wdata_f(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);

    step(bub, 1'b1, 1'b0);
    step(bub, 1'b1, 1'b0);
    chk_zero("reset");

    // ALU op passes through in one cycle
    ins = '0; ins.ev = 1; ins.rd = 5'd5; ins.alu = 32'h1234; ins.rw = 2'd1; ins.pc = 32'h40;
    issue(ins, 1, ns, nr, fa, fw, fb);
    chk("alu_stall_cycles", 32'(ns), 32'd0);
    step(bub, 1'b0, 1'b0);
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_alures", wb_alures, 32'h1234);

    // lb / lbu at 0x103, ack on first request cycle
    use_fix = 1; rdata_fix = 32'h80AA_BBCC;
    ins = '0; ins.ev = 1; ins.alu = 32'h103; ins.wds = 3'b001; ins.dmt = 3'd3;
    ins.rw = 2'd1; ins.rd = 5'd7;
    issue(ins, 1, ns, nr, fa, fw, fb);
    chk("lb_stall_cycles", 32'(ns), 32'd1);
    chk("lb_dm_addr", fa, 32'h100);
    step(bub, 1'b0, 1'b0);
    chk("lb_wb_memdata", wb_memdata, 32'hFFFF_FF80);
    ins.dmt = 3'd4;
    issue(ins, 1, ns, nr, fa, fw, fb);
    step(bub, 1'b0, 1'b0);
    chk("lbu_wb_memdata", wb_memdata, 32'h0000_0080);
    use_fix = 0;

    // sh at 0x206, ack in the 4th busy cycle (coincides with the timeout limit)
    ins = '0; ins.ev = 1; ins.alu = 32'h206; ins.rs2 = 32'h1234_ABCD;
    ins.mw = 2'd1; ins.dmt = 3'd1;
    issue(ins, 4, ns, nr, fa, fw, fb);
    chk("sh_stall_cycles", 32'(ns), 32'd4);
    chk("sh_req_cycles", 32'(nr), 32'd4);
    chk("sh_dm_be", 32'(fb), 32'hC);
    chk("sh_dm_wdata", fw, 32'hABCD_ABCD);
    step(bub, 1'b0, 1'b0);
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);

    // misaligned lw at 0x102
    ins = '0; ins.ev = 1; ins.alu = 32'h102; ins.wds = 3'b001; ins.rw = 2'd1;
    issue(ins, 1, ns, nr, fa, fw, fb);
    chk("lw_mis_req_cycles", 32'(nr), 32'd0);
    step(bub, 1'b0, 1'b0);
    chk("lw_mis_err", 32'(misalign_err), 32'd1);
    chk("lw_mis_wb_valid", 32'(wb_valid), 32'd0);
    chk("lw_mis_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    step(bub, 1'b0, 1'b0);
    chk("lw_mis_err_pulse", 32'(misalign_err), 32'd0);

    // timeout: never acked
    ins = '0; ins.ev = 1; ins.alu = 32'h400; ins.wds = 3'b001; ins.rw = 2'd1;
    issue(ins, 0, ns, nr, fa, fw, fb);
    chk("to_req_cycles", 32'(nr), 32'd4);
    ins = '0; ins.ev = 1; ins.rd = 5'd9; ins.alu = 32'h5A5A; ins.rw = 2'd1;
    step(ins, 1'b0, 1'b0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd0);
    step(bub, 1'b0, 1'b0);
    chk("to_bus_err_pulse", 32'(bus_err), 32'd0);
    chk("to_next_alu", wb_alures, 32'h5A5A);

    // reset while busy, then a stray ack
    ins = '0; ins.ev = 1; ins.alu = 32'h300; ins.wds = 3'b001; ins.rw = 2'd1;
    lat = 0;
    step(ins, 1'b0, 1'b0);
    step(ins, 1'b0, 1'b0);
    step(ins, 1'b1, 1'b0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    step(bub, 1'b0, 1'b1);
    chk_zero("post_reset");
    step(bub, 1'b0, 1'b0);
    chk("stray_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("stray_ack_req", 32'(dm_req), 32'd0);

    // randomized traffic with stray acks and random latencies
    stray_en = 1;
    for (int n = 0; n < 1500; n++) begin
      int l;
      l = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(6, 1));
      issue(rand_instr(), l, ns, nr, fa, fw, fb);
    end
    step(bub, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM fields and runs loads and stores over a req/ack data-memory bus with variable latency, including byte/halfword alignment and sign extension. It stalls the upstream pipeline while an access is outstanding and presents registered results to the MEM/WB boundary.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles without dm_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- PC_in  in  32  instruction PC.
- rd_in  in  5  destination register.
- alures_in  in  32  ALU result; this is the byte address for memory operations.
- rs2_data_in  in  32  store data, already forwarded.
- imm_in  in  32  immediate, passed through.
- MemWrite_in  in  2  nonzero = store.
- DMType_in  in  3  0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned.
- RegWrite_in  in  2  nonzero = writes rd.
- WDSel_in  in  3  3'b001 = load (writeback from memory).
- dm_req  out  1  access request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word address, i.e. {alures_in[31:2], 2'b00}.
- dm_wdata  out  32  lane-replicated write data.
- dm_be  out  4  byte enables.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  32  read word, valid when dm_ack = 1.
- mem_stall  out  1  freezes EX/MEM and all earlier stages.
- wb_valid, wb_PC, wb_rd, wb_alures, wb_memdata, wb_imm, wb_RegWrite, wb_WDSel  out  1/32/5/32/32/32/2/3  registered MEM/WB-side results.
- misalign_err  out  1  one-cycle pulse: misaligned access was dropped.
- bus_err  out  1  one-cycle pulse: the timeout fired.

## Operation
- mem_op = ex_valid & (MemWrite_in != 0 | WDSel_in == 3'b001).
- Alignment:
  - word requires addr[1:0] = 0.
  - half / half-unsigned require addr[0] = 0.
  - bytes are always aligned.
- FSM has two states, IDLE and BUSY.
  - IDLE, aligned mem_op: latch dm_* fields and go to BUSY. mem_stall = 1 combinationally in this cycle.
  - IDLE, misaligned mem_op: no request. Retire as a bubble: wb_valid = 0, wb_RegWrite = 0, misalign_err = 1 next cycle.
  - IDLE, non-memory instruction: pass through in one cycle, no stall.
  - BUSY: dm_req = 1; dm_addr, dm_we, dm_wdata and dm_be are held stable. mem_stall = !dm_ack.
  - BUSY, dm_ack = 1: capture the result into wb_* (wb_valid = 1) and return to IDLE.
  - BUSY, timeout count reaches TIMEOUT: drop dm_req, retire as a bubble with RegWrite forced to 0, pulse bus_err, return to IDLE.
- dm_ack while in IDLE is ignored.
- Store lanes:
  - byte: wdata = {4{rs2[7:0]}}, be = 4'b0001 << addr[1:0].
  - half: wdata = {2{rs2[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = rs2, be = 4'b1111.
- Load data: select the byte or half from dm_rdata by addr[1:0], then sign- or zero-extend according to DMType. For stores, wb_memdata = 0.
- Loads use dm_we = 0 and dm_be = 4'b1111.
- While mem_stall = 1, or when ex_valid = 0: wb_valid <= 0 and wb_RegWrite <= 0. Other wb_* fields may change freely.

## Timing
- Reset (synchronous, at the edge where rst = 1):
  - state = IDLE, timeout counter = 0.
  - dm_req, dm_we, dm_addr, dm_wdata and dm_be all 0.
  - every wb_* output 0; misalign_err = 0; bus_err = 0.
- Reset mid-BUSY abandons the access. A late dm_ack is ignored.
- mem_stall is combinational and is 0 during reset.
- Non-memory instruction present in cycle T: wb_* valid in T+1.
- Memory instruction present in cycle T:
  - dm_req first high in T+1.
  - dm_ack in cycle T+k (k ≥ 1): mem_stall = 1 for cycles T..T+k-1 and 0 in T+k. wb_* valid in T+k+1.
  - Minimum load/store latency is therefore 2 cycles.
- EX/MEM advances at the edge ending the ack cycle. The next instruction is evaluated in cycle T+k+1, so back-to-back accesses have no idle gap beyond this.
- Timeout: counter increments each BUSY cycle without ack. At count = TIMEOUT the abort happens at the next edge, and mem_stall is 0 in that cycle. An ack arriving in that same cycle wins over the timeout.
- misalign_err and bus_err are high for exactly one cycle.

## Test plan
- ALU op with ex_valid = 1, rd = 5, alures = 0x1234: in the next cycle wb_valid = 1, wb_rd = 5, wb_alures = 0x1234; mem_stall never asserted.
- lb at addr 0x103, dm_rdata = 0x80AA_BBCC, ack on the first req cycle: dm_addr = 0x100, mem_stall high exactly 1 cycle, wb_memdata = 0xFFFF_FF80. Same access as lbu gives 0x0000_0080.
- sh at addr 0x206 with rs2 = 0x1234_ABCD: dm_we = 1, dm_be = 4'b1100, dm_wdata = 0xABCD_ABCD. Ack delayed 3 cycles: mem_stall high for 4 cycles; req/addr/wdata stable throughout.
- lw at addr 0x102: no dm_req, misalign_err pulses, wb_valid = 0, wb_RegWrite = 0.
- TIMEOUT = 4, ack never sent: dm_req high for 4 cycles, then dropped; bus_err pulses; a subsequent ALU op passes through normally.
- rst during BUSY followed by a stray dm_ack: all outputs read 0 after reset, the FSM stays in IDLE, and no wb_valid is produced.
